tdm_demux_8: RTL and testbench
==============================

Name: tdm_demux_8

Overview:
- Time-division demultiplexer: the receive end of an 8-channel TDM link whose transmit end is an 8:1 mux driven by a 3-bit slot select.
- Accepts one W-bit sample per enabled cycle, tracks the slot number, and assembles the 8 samples of a frame in a shadow register.
- Presents the complete frame in parallel with a one-cycle valid pulse.
- Exports its slot counter so the same counter can drive the transmit-side mux select in loopback.

Parameters:
- W, 1, width of each channel sample in bits. Channel count is fixed at 8.

Ports:
- clk  input  1  rising-edge clock, single domain
- rst  input  1  synchronous, active-high reset
- en  input  1  sample strobe; d and sync are valid this cycle
- sync  input  1  frame marker; qualified by en; marks the sample as slot 0
- d  input  W  serial sample for the current slot
- o  output  8*W  last complete frame; slot k occupies o[W*k +: W]
- s  output  3  current slot counter, i.e. the slot the next en sample is written to
- valid  output  1  one-cycle pulse: o has just been updated
- err  output  1  one-cycle pulse: sync arrived mid-frame and the partial frame was dropped

Behaviour:
- Reset: when rst=1 at a clock edge, the block goes to state HUNT and clears s=0, o=0, shadow=0, valid=0, err=0. rst has priority over en and sync. Reset mid-frame discards the partial frame.
- All outputs are registered. valid and err default to 0 every cycle unless set as described below.
- HUNT state:
  - en=0, or en=1 with sync=0: no change, s stays 0.
  - en=1 with sync=1: shadow slot 0 <= d, s <= 1, go to RUN.
- RUN state, en=0: hold everything. s, shadow and o are unchanged; gaps of any length are allowed.
- RUN state, en=1 with sync=0:
  - s != 7: shadow slot s <= d, s <= s+1.
  - s == 7: o <= {d, shadow slots 6..0}, valid <= 1, s <= 0 (wrap). Stay in RUN.
- RUN state, en=1 with sync=1:
  - s == 0: normal slot-0 capture. sync is optional at slot 0; free-running frames without sync are accepted.
  - s != 0: misalignment. err <= 1, o unchanged, no valid, shadow slot 0 <= d, s <= 1. The unfinished shadow contents are abandoned and are never output.
- Latency: o and valid are visible in the cycle after the clock edge that samples the slot-7 en. Back-to-back frames with en held high give a valid pulse every 8 cycles.
- err and valid are never asserted in the same cycle, because the slot-7 capture path and the resync path are mutually exclusive.
- The shadow register is internal. Stale shadow slots are overwritten before reuse, so they are never exposed on o.
- No backpressure. The consumer must take o within 8 enabled samples; o stays stable between valid pulses.
- Loopback: s is the live slot counter. Feeding s to the transmit-side mux select, with the transmitter's output wired to d and en=1, reconstructs the transmitted word one frame later.

Test Plan:
- Reset, then en=1 for 8 cycles, d = bits of 8'hA5 LSB first, sync=1 only on the first -> s steps 0..7..0; valid=1 for exactly one cycle after the 8th sample; o=8'hA5; err=0.
- Same frame with en deasserted for 3 cycles after slot 2 and 1 cycle after slot 5 -> s holds during the gaps; o=8'hA5; valid asserted once, one cycle after the slot-7 sample.
- After reset, 10 en cycles of d=1 with sync=0 -> s stays 0, valid=0, o=0. Then sync=1 on the next en starts capture at slot 0.
- Frame 8'h3C, then sync pulsed at slot 4 of the next frame with d=1 -> err=1 for one cycle, o stays 8'h3C, s=1 afterwards. The following 7 samples complete a frame 8'hC3 with valid=1.
- Continuous en, frames 8'h3C then 8'hC3 with no sync on the second -> two valid pulses exactly 8 cycles apart; o=8'h3C then 8'hC3.
- rst=1 with en=1 at slot 5 -> next cycle s=0, o=0, valid=0, err=0, state HUNT. A subsequent sync frame 8'h81 captures correctly.

Source files
------------

// File: rtl/tdm_demux_8.sv
// rtl/tdm_demux_8.sv - 8-channel TDM receive demultiplexer with frame assembly
//
// Purpose:
//    Receive end of an 8-channel time-division link. Each enabled cycle
//    carries one W-bit sample for the current slot. Slots 0..6 are collected
//    in a shadow register. The slot-7 sample completes the frame, which is
//    then published on o together with a one-cycle valid pulse. A sync
//    marker arriving anywhere but slot 0 drops the partial frame, raises a
//    one-cycle err pulse and restarts capture at slot 0.
//
// Ports:
//    clk    in   1     rising-edge clock
//    rst    in   1     synchronous active-high reset, overrides en/sync
//    en     in   1     sample strobe; d and sync are valid when high
//    sync   in   1     frame marker, qualified by en; marks the sample as slot 0
//    d      in   W     sample for the current slot
//    o      out  8*W   last complete frame; slot k at o[W*k +: W]
//    s      out  3     slot that the next enabled sample is written to
//    valid  out  1     one-cycle pulse: o has just been updated
//    err    out  1     one-cycle pulse: mid-frame sync, partial frame dropped

module tdm_demux_8 #(
   parameter int W = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           sync,
   input  logic [W-1:0]   d,
   output logic [8*W-1:0] o,
   output logic [2:0]     s,
   output logic           valid,
   output logic           err
);

   typedef enum logic {
      ST_HUNT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           r_state;
   logic [2:0]       r_slot;
   // Only slots 0..6 need storage: slot 7 goes straight from d into the frame.
   logic [7*W-1:0]   r_shadow;
   logic [8*W-1:0]   r_frame;
   logic             r_valid;
   logic             r_err;

   logic             w_last_slot;
   logic             w_resync;

   assign w_last_slot = (r_slot == 3'd7);
   // sync at slot 0 is an ordinary (optional) frame marker; anywhere else
   // it means the link slipped and the partial frame must be abandoned.
   assign w_resync    = sync && (r_slot != 3'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_HUNT;
         r_slot   <= 3'd0;
         r_shadow <= '0;
         r_frame  <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;

         case (r_state)
            ST_HUNT: begin
               // Samples before the first sync carry no alignment and are ignored.
               if (en && sync) begin
                  r_shadow[W-1:0] <= d;
                  r_slot          <= 3'd1;
                  r_state         <= ST_RUN;
               end
            end

            ST_RUN: begin
               if (en) begin
                  if (w_resync) begin
                     r_err           <= 1'b1;
                     r_shadow[W-1:0] <= d;
                     r_slot          <= 3'd1;
                  end else if (w_last_slot) begin
                     r_frame <= {d, r_shadow};
                     r_valid <= 1'b1;
                     r_slot  <= 3'd0;
                  end else begin
                     for (int k = 0; k < 7; k++) begin
                        if (r_slot == 3'(k)) begin
                           r_shadow[W*k +: W] <= d;
                        end
                     end
                     r_slot <= r_slot + 3'd1;
                  end
               end
            end

            default: begin
               r_state <= ST_HUNT;
               r_slot  <= 3'd0;
            end
         endcase
      end
   end

   assign o     = r_frame;
   assign s     = r_slot;
   assign valid = r_valid;
   assign err   = r_err;

endmodule

// File: tb/tb_tdm_demux_8.sv
// tb/tb_tdm_demux_8.sv - self-checking bench for tdm_demux_8
//
// Purpose:
//    Directed steps from the test plan followed by randomized traffic, all
//    compared cycle by cycle against a queue-based reference model of the
//    receiver, plus literal frame values for the directed frames.
//
// Ports: none (top-level bench).

module tb_tdm_demux_8;

   localparam int W = 1;

   logic           clk;
   logic           rst;
   logic           en;
   logic           sync;
   logic [W-1:0]   d;
   logic [8*W-1:0] o;
   logic [2:0]     s;
   logic           valid;
   logic           err;

   int total;
   int bad;

   // Reference model: a frame is simply the list of samples received since
   // alignment; its length is the slot number.
   logic           m_locked;
   logic [W-1:0]   m_q[$];
   logic [8*W-1:0] m_o;
   logic           m_valid;
   logic           m_err;
   int             m_valid_count;
   int             m_err_count;

   tdm_demux_8 #(.W(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .sync  (sync),
      .d     (d),
      .o     (o),
      .s     (s),
      .valid (valid),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_step(input logic r, input logic e, input logic sy, input logic [W-1:0] dd);
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (r) begin
         m_locked = 1'b0;
         m_q.delete();
         m_o = '0;
      end else if (e) begin
         if (!m_locked) begin
            if (sy) begin
               m_locked = 1'b1;
               m_q.push_back(dd);
            end
         end else begin
            if (sy && m_q.size() != 0) begin
               m_err = 1'b1;
               m_q.delete();
            end
            m_q.push_back(dd);
            if (m_q.size() == 8) begin
               for (int k = 0; k < 8; k++) m_o[W*k +: W] = m_q[k];
               m_valid = 1'b1;
               m_q.delete();
            end
         end
      end
   endtask

   task automatic step(input logic r, input logic e, input logic sy, input logic [W-1:0] dd);
      logic [2:0] exp_s;
      rst  = r;
      en   = e;
      sync = sy;
      d    = dd;
      @(posedge clk);
      model_step(r, e, sy, dd);
      if (m_valid) m_valid_count++;
      if (m_err)   m_err_count++;
      exp_s = 3'(m_q.size());
      #1;
      total++;
      assert (o === m_o) else begin
         bad++;
         $error("FAIL o t=%0t got=%h exp=%h", $time, o, m_o);
      end
      total++;
      assert (s === exp_s) else begin
         bad++;
         $error("FAIL s t=%0t got=%0d exp=%0d", $time, s, exp_s);
      end
      total++;
      assert (valid === m_valid) else begin
         bad++;
         $error("FAIL valid t=%0t got=%b exp=%b", $time, valid, m_valid);
      end
      total++;
      assert (err === m_err) else begin
         bad++;
         $error("FAIL err t=%0t got=%b exp=%b", $time, err, m_err);
      end
   endtask

   task automatic check_o(input string tag, input logic [8*W-1:0] exp);
      total++;
      assert (o === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, o, exp);
      end
   endtask

   task automatic check_count(input string tag, input int got, input int exp);
      total++;
      assert (got == exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Send one byte LSB first, sync only on slot 0 if requested; gap_after[k]
   // idle cycles follow the slot-k sample.
   task automatic send_frame(input logic [7:0] b, input logic with_sync,
                             input int gap_at_a, input int gap_len_a,
                             input int gap_at_b, input int gap_len_b);
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 1'b1, (k == 0) ? with_sync : 1'b0, W'(b[k]));
         if (k == gap_at_a) for (int g = 0; g < gap_len_a; g++) step(1'b0, 1'b0, 1'b0, W'($urandom_range(1, 0)));
         if (k == gap_at_b) for (int g = 0; g < gap_len_b; g++) step(1'b0, 1'b0, 1'b0, W'($urandom_range(1, 0)));
      end
   endtask

   initial begin
      logic [7:0] c3;
      int         vc;
      int         ec;
      total = 0;
      bad   = 0;
      m_locked = 1'b0;
      m_o = '0;
      m_valid = 1'b0;
      m_err = 1'b0;
      m_valid_count = 0;
      m_err_count = 0;
      rst = 1'b1;
      en = 1'b0;
      sync = 1'b0;
      d = '0;

      // Reset state.
      step(1'b1, 1'b0, 1'b0, '0);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      check_o("reset_o", 8'h00);

      // Plain A5 frame with sync on slot 0.
      vc = m_valid_count;
      send_frame(8'hA5, 1'b1, -1, 0, -1, 0);
      check_o("a5_o", 8'hA5);
      check_count("a5_valid_pulses", m_valid_count - vc, 1);

      // Same frame with gaps after slot 2 (3 cycles) and slot 5 (1 cycle).
      vc = m_valid_count;
      send_frame(8'hA5, 1'b1, 2, 3, 5, 1);
      check_o("a5_gap_o", 8'hA5);
      check_count("a5_gap_valid_pulses", m_valid_count - vc, 1);

      // Hunting: unsynced samples are ignored, then a sync frame is taken.
      step(1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
      check_o("hunt_o", 8'h00);
      send_frame(8'h5A, 1'b1, -1, 0, -1, 0);
      check_o("hunt_then_sync_o", 8'h5A);

      // 3C, then misaligned sync at slot 4 of the next frame.
      send_frame(8'h3C, 1'b1, -1, 0, -1, 0);
      check_o("3c_o", 8'h3C);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
      ec = m_err_count;
      step(1'b0, 1'b1, 1'b1, 1'b1);
      check_count("misalign_err_pulses", m_err_count - ec, 1);
      check_o("misalign_o_held", 8'h3C);
      c3 = 8'hC3;
      for (int k = 1; k < 8; k++) step(1'b0, 1'b1, 1'b0, W'(c3[k]));
      check_o("c3_after_resync", 8'hC3);

      // Continuous 3C then C3 without sync on the second frame.
      vc = m_valid_count;
      send_frame(8'h3C, 1'b0, -1, 0, -1, 0);
      check_o("cont_3c", 8'h3C);
      send_frame(8'hC3, 1'b0, -1, 0, -1, 0);
      check_o("cont_c3", 8'hC3);
      check_count("cont_valid_pulses", m_valid_count - vc, 2);

      // Reset at slot 5 with en high, then 81.
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, (k == 0), 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      check_o("mid_reset_o", 8'h00);
      send_frame(8'h81, 1'b1, -1, 0, -1, 0);
      check_o("after_reset_81", 8'h81);

      // Randomized traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(99, 0) < 2), ($urandom_range(99, 0) < 75),
              ($urandom_range(99, 0) < 8), W'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
